ex_hazard_sequencer: RTL and testbench

- Sequences the EX-stage instruction-source select (IRSrcALU) of the pipelined core, plus the matching PC and IF/ID write enables.
- Inserts NOP bubbles for load-use hazards.
- On a taken BNE, selects the BNE redirect word for one cycle, then flushes with NOPs.
- Sits beside the EX-stage instruction mux; also exports saturating stall/flush counters for debug.

---
 rtl/ex_hazard_sequencer_pkg.sv | 16 +
 rtl/ex_hazard_sequencer_sat_counter.sv | 32 +++
 rtl/ex_hazard_sequencer.sv | 150 +++++++++++++++
 tb/tb_ex_hazard_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_hazard_sequencer_pkg.sv
// Shared encodings for the EX-stage hazard sequencer.
// Instruction-source selects and FSM state values.
package ex_hazard_sequencer_pkg;

    localparam logic [1:0] SRC_EXID = 2'b00;
    localparam logic [1:0] SRC_NOP  = 2'b01;
    localparam logic [1:0] SRC_BNE  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

endpackage

// File: rtl/ex_hazard_sequencer_sat_counter.sv
// Saturating up-counter used for the debug stall/flush event counts.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_hazard_sequencer.sv
// EX-stage instruction-source sequencer: load-use bubbles and BNE
// redirect/flush, with registered PC and IF/ID write enables.
module ex_hazard_sequencer
    import ex_hazard_sequencer_pkg::*;
#(
    parameter int REG_ADDR_W          = 5,
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 2,
    parameter int CNT_W               = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EX_MemRead,
    input  logic [REG_ADDR_W-1:0] EX_rd,
    input  logic [REG_ADDR_W-1:0] ID_rs,
    input  logic [REG_ADDR_W-1:0] ID_rt,
    input  logic                  BNE_taken,
    output logic [1:0]            IRSrcALU,
    output logic                  PCWrite,
    output logic                  IF_IDWrite,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(BRANCH_FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] src_q, src_d;
    logic       pcw_q, pcw_d;
    logic       ifw_q, ifw_d;
    logic       busy_q;
    logic       hz;
    logic       stall_inc;
    logic       flush_inc;

    assign hz = EX_MemRead && (EX_rd != '0)
             && ((EX_rd == ID_rs) || (EX_rd == ID_rt));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (BNE_taken) begin
                    state_d   = ST_REDIRECT;
                    flush_inc = 1'b1;
                end else if (hz) begin
                    state_d   = ST_STALL;
                    cnt_d     = STALL_INIT;
                    stall_inc = 1'b1;
                end
            end
            ST_STALL: begin
                // a taken branch abandons the remaining bubbles
                if (BNE_taken) begin
                    state_d   = ST_REDIRECT;
                    flush_inc = 1'b1;
                end else if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_REDIRECT: begin
                if (BRANCH_FLUSH_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                    cnt_d   = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs follow the state being entered, so they are registered
    always_comb begin
        src_d = SRC_EXID;
        pcw_d = 1'b1;
        ifw_d = 1'b1;
        unique case (state_d)
            ST_IDLE: begin
                src_d = SRC_EXID;
            end
            ST_STALL: begin
                src_d = SRC_NOP;
                pcw_d = 1'b0;
                ifw_d = 1'b0;
            end
            ST_REDIRECT: begin
                src_d = SRC_BNE;
                ifw_d = 1'b0;
            end
            ST_FLUSH: begin
                src_d = SRC_NOP;
            end
            default: src_d = SRC_EXID;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            src_q   <= SRC_EXID;
            pcw_q   <= 1'b1;
            ifw_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            pcw_q   <= pcw_d;
            ifw_q   <= ifw_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush_inc),
        .cnt_o (flush_count)
    );

    assign IRSrcALU   = src_q;
    assign PCWrite    = pcw_q;
    assign IF_IDWrite = ifw_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// Directed bench for ex_hazard_sequencer: three parameterisations
// share one stimulus stream; each check targets one instance.
module tb_ex_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       EX_MemRead;
    logic       BNE_taken;
    logic [4:0] EX_rd, ID_rs, ID_rt;

    logic [1:0]  a_src, b_src, c_src;
    logic        a_pcw, b_pcw, c_pcw;
    logic        a_ifw, b_ifw, c_ifw;
    logic        a_busy, b_busy, c_busy;
    logic [15:0] a_sc, a_fc, c_sc, c_fc;
    logic [3:0]  b_sc, b_fc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // defaults
    ex_hazard_sequencer dut_a (
        .clk(clk), .rst(rst), .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .BNE_taken(BNE_taken),
        .IRSrcALU(a_src), .PCWrite(a_pcw), .IF_IDWrite(a_ifw),
        .busy(a_busy), .stall_count(a_sc), .flush_count(a_fc)
    );

    // three-cycle stall, narrow counters
    ex_hazard_sequencer #(
        .LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .BNE_taken(BNE_taken),
        .IRSrcALU(b_src), .PCWrite(b_pcw), .IF_IDWrite(b_ifw),
        .busy(b_busy), .stall_count(b_sc), .flush_count(b_fc)
    );

    // no flush cycles after redirect
    ex_hazard_sequencer #(.BRANCH_FLUSH_CYCLES(0)) dut_c (
        .clk(clk), .rst(rst), .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .BNE_taken(BNE_taken),
        .IRSrcALU(c_src), .PCWrite(c_pcw), .IF_IDWrite(c_ifw),
        .busy(c_busy), .stall_count(c_sc), .flush_count(c_fc)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        EX_MemRead = 1'b0;
        BNE_taken  = 1'b0;
        EX_rd      = 5'd0;
        ID_rs      = 5'd0;
        ID_rt      = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic hazard(input logic [4:0] rd);
        EX_MemRead = 1'b1;
        EX_rd      = rd;
        ID_rt      = rd;
    endtask

    task automatic wait_idle_b();
        int k = 0;
        while (b_busy && k < 10) begin
            step();
            k++;
        end
        if (b_busy) chk("b_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        BNE_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_src", a_src, 2'b00);
            chk("rst_pcw", a_pcw, 1'b1);
            chk("rst_ifw", a_ifw, 1'b1);
            chk("rst_busy", a_busy, 1'b0);
            chk("rst_sc", a_sc, 16'd0);
            chk("rst_fc", a_fc, 16'd0);
        end
        rst = 1'b0;
        BNE_taken = 1'b0;
        step();
        chk("idle_src", a_src, 2'b00);

        // load-use on rt
        hazard(5'd5);
        step();
        idle_in();
        chk("lu_src", a_src, 2'b01);
        chk("lu_pcw", a_pcw, 1'b0);
        chk("lu_ifw", a_ifw, 1'b0);
        chk("lu_busy", a_busy, 1'b1);
        chk("lu_sc", a_sc, 16'd1);
        step();
        chk("lu_end_src", a_src, 2'b00);
        chk("lu_end_pcw", a_pcw, 1'b1);
        chk("lu_end_busy", a_busy, 1'b0);

        // r0 never hazards; no MemRead never hazards
        EX_MemRead = 1'b1;
        step();
        idle_in();
        chk("r0_src", a_src, 2'b00);
        chk("r0_sc", a_sc, 16'd1);
        EX_rd = 5'd7;
        ID_rs = 5'd7;
        step();
        idle_in();
        chk("nold_src", a_src, 2'b00);

        // hazard via rs
        EX_MemRead = 1'b1;
        EX_rd = 5'd9;
        ID_rs = 5'd9;
        step();
        idle_in();
        chk("rs_src", a_src, 2'b01);
        chk("rs_sc", a_sc, 16'd2);
        step();

        // BNE with a squashed second pulse
        do_reset();
        BNE_taken = 1'b1;
        step();
        BNE_taken = 1'b0;
        chk("bne_src1", a_src, 2'b10);
        chk("bne_pcw1", a_pcw, 1'b1);
        chk("bne_ifw1", a_ifw, 1'b0);
        chk("bne_fc1", a_fc, 16'd1);
        step();
        chk("bne_src2", a_src, 2'b01);
        chk("bne_ifw2", a_ifw, 1'b1);
        BNE_taken = 1'b1;
        step();
        BNE_taken = 1'b0;
        chk("bne_src3", a_src, 2'b01);
        step();
        chk("bne_src4", a_src, 2'b00);
        chk("bne_busy4", a_busy, 1'b0);
        chk("bne_fc4", a_fc, 16'd1);

        // simultaneous: branch wins
        do_reset();
        hazard(5'd3);
        BNE_taken = 1'b1;
        step();
        idle_in();
        chk("sim_src1", a_src, 2'b10);
        chk("sim_sc", a_sc, 16'd0);
        chk("sim_fc", a_fc, 16'd1);
        step();
        chk("sim_src2", a_src, 2'b01);
        step();
        chk("sim_src3", a_src, 2'b01);
        step();
        chk("sim_src4", a_src, 2'b00);

        // branch pre-empts a 3-cycle stall, then reset mid-flush
        do_reset();
        hazard(5'd4);
        step();
        idle_in();
        chk("pre_src1", b_src, 2'b01);
        step();
        chk("pre_src2", b_src, 2'b01);
        BNE_taken = 1'b1;
        step();
        BNE_taken = 1'b0;
        chk("pre_src3", b_src, 2'b10);
        chk("pre_sc", b_sc, 4'd1);
        chk("pre_fc", b_fc, 4'd1);
        step();
        chk("pre_flush", b_src, 2'b01);
        chk("pre_busy", b_busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_src", b_src, 2'b00);
        chk("mrst_pcw", b_pcw, 1'b1);
        chk("mrst_ifw", b_ifw, 1'b1);
        chk("mrst_busy", b_busy, 1'b0);
        chk("mrst_fc", b_fc, 4'd0);

        // saturation on 4-bit counter
        for (int i = 0; i < 20; i++) begin
            hazard(5'd6);
            step();
            idle_in();
            wait_idle_b();
            if (i == 14) chk("sat_15", b_sc, 4'd15);
        end
        chk("sat_hold", b_sc, 4'd15);

        // zero flush cycles
        do_reset();
        BNE_taken = 1'b1;
        step();
        BNE_taken = 1'b0;
        chk("nf_src1", c_src, 2'b10);
        chk("nf_ifw1", c_ifw, 1'b0);
        step();
        chk("nf_src2", c_src, 2'b00);
        chk("nf_busy2", c_busy, 1'b0);
        chk("nf_fc", c_fc, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
